// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single-ported memory: one access at a time, reads return via per-requester rdata.
// Optional round-robin tie breaking is enabled by defining ARB_ROUND_ROBIN_EN; otherwise requester 0 wins ties.
module mem_port_arbiter #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic         we0,
    input  logic         we1,
    input  logic [n-1:0] addr0,
    input  logic [n-1:0] addr1,
    input  logic [n-1:0] wdata0,
    input  logic [n-1:0] wdata1,
    output logic         gnt0,
    output logic         gnt1,
    output logic [n-1:0] rdata0,
    output logic [n-1:0] rdata1,
    output logic         rvalid0,
    output logic         rvalid1,
    output logic [n-1:0] mem_wr_data,
    output logic [n-1:0] mem_wr_addr,
    output logic         mem_wr_en,
    output logic [n-1:0] mem_rd_addr,
    input  logic [n-1:0] mem_rd_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_nextState;
    logic         r_owner;
    logic         r_we;
    logic [n-1:0] r_addr;
    logic [n-1:0] r_wdata;
    logic [n-1:0] r_rdata0;
    logic [n-1:0] r_rdata1;
    logic         r_gnt0;
    logic         r_gnt1;
    logic         r_rvalid0;
    logic         r_rvalid1;
    logic         r_memWrEn;
    logic         w_start;
    logic         w_winner;
    logic         w_nextOwner;
    logic         w_nextWe;

    assign w_start = req0 | req1;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_lastOwner;

    assign w_winner = (req0 && req1) ? ~r_lastOwner : req1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lastOwner <= 1'b1;
        end else if (r_state == ST_IDLE && w_start) begin
            r_lastOwner <= w_winner;
        end
    end
`else
    assign w_winner = ~req0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextOwner = r_owner;
        w_nextWe    = r_we;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_nextState = ST_XFER;
                    w_nextOwner = w_winner;
                    w_nextWe    = w_winner ? we1 : we0;
                end
            end
            ST_XFER: w_nextState = r_we ? ST_IDLE : ST_RESP;
            ST_RESP: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Request fields are captured once at arbitration so requesters may change them after gnt
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (r_state == ST_IDLE && w_start) begin
                r_owner <= w_winner;
                r_we    <= w_winner ? we1 : we0;
                r_addr  <= w_winner ? addr1 : addr0;
                r_wdata <= w_winner ? wdata1 : wdata0;
            end
            if (r_state == ST_XFER && !r_we) begin
                if (r_owner) begin
                    r_rdata1 <= mem_rd_data;
                end else begin
                    r_rdata0 <= mem_rd_data;
                end
            end
        end
    end

    // Strobes come straight from flops, decoded one cycle early from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_memWrEn <= 1'b0;
        end else begin
            r_gnt0    <= (w_nextState == ST_XFER) && !w_nextOwner;
            r_gnt1    <= (w_nextState == ST_XFER) &&  w_nextOwner;
            r_rvalid0 <= (w_nextState == ST_RESP) && !w_nextOwner;
            r_rvalid1 <= (w_nextState == ST_RESP) &&  w_nextOwner;
            r_memWrEn <= (w_nextState == ST_XFER) &&  w_nextWe;
        end
    end

    assign gnt0        = r_gnt0;
    assign gnt1        = r_gnt1;
    assign rvalid0     = r_rvalid0;
    assign rvalid1     = r_rvalid1;
    assign rdata0      = r_rdata0;
    assign rdata1      = r_rdata1;
    assign mem_wr_en   = r_memWrEn;
    assign mem_wr_addr = r_addr;
    assign mem_wr_data = r_wdata;
    assign mem_rd_addr = r_addr;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Tie expectations follow ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_mem_port_arbiter;

    localparam int N = 8;

    logic         clk;
    logic         reset;
    logic         req     [2];
    logic         weV     [2];
    logic [N-1:0] addrV   [2];
    logic [N-1:0] wdataV  [2];
    logic         gnt0, gnt1, rvalid0, rvalid1, mem_wr_en;
    logic [N-1:0] rdata0, rdata1, mem_wr_data, mem_wr_addr, mem_rd_addr, mem_rd_data;
    logic [1:0]   gntV, rvalidV;

    logic [N-1:0] mem    [256];
    logic [N-1:0] refMem [256];
    logic [N-1:0] expRdata [2];
    int           lastOwner;
    int           checks;
    int           failures;
    logic         tbInit;
    logic         tbWrEn;
    logic [N-1:0] tbWrAddr, tbWrData;

    mem_port_arbiter #(.n(N)) dut (
        .clk(clk), .reset(reset),
        .req0(req[0]), .req1(req[1]), .we0(weV[0]), .we1(weV[1]),
        .addr0(addrV[0]), .addr1(addrV[1]), .wdata0(wdataV[0]), .wdata1(wdataV[1]),
        .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .mem_wr_data(mem_wr_data), .mem_wr_addr(mem_wr_addr), .mem_wr_en(mem_wr_en),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
    );

    assign gntV        = {gnt1, gnt0};
    assign rvalidV     = {rvalid1, rvalid0};
    assign mem_rd_data = mem[mem_rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory seen by the arbiter; the bench can also fill or poke it
    always @(posedge clk) begin
        if (tbInit) begin
            for (int i = 0; i < 256; i++) mem[i] <= N'(i * 7 + 3);
        end else if (mem_wr_en) begin
            mem[mem_wr_addr] <= mem_wr_data;
        end else if (tbWrEn) begin
            mem[tbWrAddr] <= tbWrData;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int p, input logic we, input logic [N-1:0] a, input logic [N-1:0] d);
        req[p]    = 1'b1;
        weV[p]    = we;
        addrV[p]  = a;
        wdataV[p] = d;
    endtask

    function automatic int tieWinner();
`ifdef ARB_ROUND_ROBIN_EN
        return (lastOwner == 1) ? 0 : 1;
`else
        return 0;
`endif
    endfunction

    // Runs one granted access for requester p whose req is already high and whose turn it is
    task automatic finishTxn(input int p, input bit keep);
        logic         we;
        logic [N-1:0] a, d;
        we = weV[p];
        a  = addrV[p];
        d  = wdataV[p];
        @(posedge clk); #1;
        checkOutput("gnt", 32'(gntV), (p == 1) ? 32'd2 : 32'd1);
        checkOutput("wr_en", 32'(mem_wr_en), 32'(we));
        checkOutput("rd_addr", 32'(mem_rd_addr), 32'(a));
        if (we) begin
            checkOutput("wr_addr", 32'(mem_wr_addr), 32'(a));
            checkOutput("wr_data", 32'(mem_wr_data), 32'(d));
        end
        lastOwner = p;
        if (!keep) req[p] = 1'b0;
        @(posedge clk); #1;
        checkOutput("gnt_off", 32'(gntV), 32'd0);
        checkOutput("wr_en_off", 32'(mem_wr_en), 32'd0);
        if (we) begin
            refMem[a] = d;
            checkOutput("mem_written", 32'(mem[a]), 32'(d));
            checkOutput("rvalid_none", 32'(rvalidV), 32'd0);
        end else begin
            expRdata[p] = refMem[a];
            checkOutput("rvalid", 32'(rvalidV), (p == 1) ? 32'd2 : 32'd1);
            checkOutput("rdata0", 32'(rdata0), 32'(expRdata[0]));
            checkOutput("rdata1", 32'(rdata1), 32'(expRdata[1]));
            @(posedge clk); #1;
            checkOutput("rvalid_off", 32'(rvalidV), 32'd0);
            checkOutput("gnt_idle", 32'(gntV), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int w;
        int mode;
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        tbInit    = 1'b1;
        tbWrEn    = 1'b0;
        tbWrAddr  = '0;
        tbWrData  = '0;
        lastOwner = 1;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; weV[p] = 1'b0; addrV[p] = '0; wdataV[p] = '0; expRdata[p] = '0;
        end
        for (int i = 0; i < 256; i++) refMem[i] = N'(i * 7 + 3);
        repeat (2) @(posedge clk);
        #1;
        tbInit = 1'b0;

        // Reset state
        checkOutput("rst_gnt", 32'(gntV), 32'd0);
        checkOutput("rst_rvalid", 32'(rvalidV), 32'd0);
        checkOutput("rst_wr_en", 32'(mem_wr_en), 32'd0);
        checkOutput("rst_rdata0", 32'(rdata0), 32'd0);
        checkOutput("rst_rdata1", 32'(rdata1), 32'd0);
        checkOutput("rst_wr_addr", 32'(mem_wr_addr), 32'd0);
        checkOutput("rst_wr_data", 32'(mem_wr_data), 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // Single write then single read on the other port
        applyStimulus(0, 1'b1, 8'h10, 8'hA5);
        finishTxn(0, 1'b0);
        tbWrEn = 1'b1; tbWrAddr = 8'h20; tbWrData = 8'h3C;
        @(posedge clk); #1;
        tbWrEn = 1'b0;
        refMem[8'h20] = 8'h3C;
        applyStimulus(1, 1'b0, 8'h20, 8'h00);
        finishTxn(1, 1'b0);
        checkOutput("read_rdata1", 32'(rdata1), 32'h3C);

        // Back-to-back write then read of the same location
        applyStimulus(0, 1'b1, 8'h01, 8'h05);
        finishTxn(0, 1'b0);
        applyStimulus(0, 1'b0, 8'h01, 8'h00);
        finishTxn(0, 1'b0);
        checkOutput("b2b_rdata0", 32'(rdata0), 32'h05);

        // Withdrawn request during the response cycle
        applyStimulus(0, 1'b0, 8'h33, 8'h00);
        @(posedge clk); #1;
        checkOutput("wd_gnt0", 32'(gntV), 32'd1);
        req[0] = 1'b0;
        lastOwner = 0;
        @(posedge clk); #1;
        expRdata[0] = refMem[8'h33];
        checkOutput("wd_rvalid0", 32'(rvalidV), 32'd1);
        checkOutput("wd_rdata0", 32'(rdata0), 32'(expRdata[0]));
        applyStimulus(1, 1'b1, 8'h33, ~refMem[8'h33]);
        @(posedge clk); #1;
        req[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checkOutput("wd_no_gnt", 32'(gntV), 32'd0);
            checkOutput("wd_no_wr", 32'(mem_wr_en), 32'd0);
        end
        checkOutput("wd_mem", 32'(mem[8'h33]), 32'(refMem[8'h33]));

        // Reset during the transfer cycle of a write
        applyStimulus(0, 1'b1, 8'h40, ~refMem[8'h40]);
        @(posedge clk); #1;
        checkOutput("abort_gnt", 32'(gntV), 32'd1);
        checkOutput("abort_wr_en", 32'(mem_wr_en), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("abort_gnt_drop", 32'(gntV), 32'd0);
        checkOutput("abort_wr_drop", 32'(mem_wr_en), 32'd0);
        req[0] = 1'b0;
        @(posedge clk);
        @(negedge clk) reset = 1'b1;
        lastOwner   = 1;
        expRdata[0] = '0;
        expRdata[1] = '0;
        @(posedge clk); #1;
        checkOutput("abort_gnt_idle", 32'(gntV), 32'd0);
        checkOutput("abort_rvalid", 32'(rvalidV), 32'd0);
        checkOutput("abort_wr_en_idle", 32'(mem_wr_en), 32'd0);
        checkOutput("abort_rdata0", 32'(rdata0), 32'd0);
        checkOutput("abort_rdata1", 32'(rdata1), 32'd0);
        checkOutput("abort_wr_addr", 32'(mem_wr_addr), 32'd0);
        checkOutput("abort_mem", 32'(mem[8'h40]), 32'(refMem[8'h40]));

        // Both requesters held high for reads
        applyStimulus(0, 1'b0, 8'h40, 8'h00);
        applyStimulus(1, 1'b0, 8'h20, 8'h00);
        for (int k = 0; k < 4; k++) begin
            w = tieWinner();
            finishTxn(w, (k != 3));
        end
        req[0] = 1'b0;
        req[1] = 1'b0;

        // Random traffic: single requests and ties
        for (int it = 0; it < 40; it++) begin
            mode = int'($urandom_range(0, 2));
            if (mode < 2) begin
                applyStimulus(mode, 1'($urandom), N'($urandom), N'($urandom));
                finishTxn(mode, 1'b0);
            end else begin
                applyStimulus(0, 1'($urandom), N'($urandom), N'($urandom));
                applyStimulus(1, 1'($urandom), N'($urandom), N'($urandom));
                w = tieWinner();
                finishTxn(w, 1'b0);
                finishTxn(1 - w, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
